// File: rtl/ftoi_pkg.sv
// Shared types for the float-to-integer pipeline: rounding modes, flag
// bit positions and operand classes.
package ftoi_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RDN = 2'b10,
    RM_RUP = 2'b11
  } rm_e;

  typedef enum logic [1:0] {
    CLS_ZERO   = 2'b00,
    CLS_NORMAL = 2'b01,
    CLS_INF    = 2'b10,
    CLS_NAN    = 2'b11
  } cls_e;

  localparam int FLAG_INVALID = 1;
  localparam int FLAG_INEXACT = 0;

  // Saturation bound for an out-of-range magnitude of the given sign.
  function automatic logic [63:0] sat_bound(input logic sign, input logic uns, input int w);
    logic [63:0] umax_v;
    logic [63:0] smax_v;
    logic [63:0] smin_v;
    umax_v = {64{1'b1}} >> (64 - w);
    smax_v = umax_v >> 1;
    smin_v = smax_v + 64'd1;
    if (sign) begin
      sat_bound = uns ? 64'd0 : smin_v;
    end else begin
      sat_bound = uns ? umax_v : smax_v;
    end
  endfunction

endpackage

// File: rtl/ftoi_round.sv
// Stage-2 combinational round / negate / saturate / flag generation on an
// aligned magnitude with integer part, guard bit and sticky bit.
module ftoi_round
  import ftoi_pkg::*;
#(
  parameter int INT_W = 32
) (
  input  logic             sign,
  input  cls_e             cls,
  input  logic             huge,
  input  logic [INT_W-1:0] int_mag,
  input  logic             guard,
  input  logic             sticky,
  input  rm_e              rm,
  input  logic             uns,
  output logic [INT_W-1:0] result,
  output logic [1:0]       flags
);

  logic             inexact_s;
  logic             round_up_s;
  logic [INT_W:0]   mag_rnd_s;
  logic [INT_W-1:0] sat_val_s;
  logic [INT_W-1:0] umax_s;
  logic [INT_W-1:0] smax_s;
  logic             pos_ovf_s;
  logic             neg_ovf_s;

  assign umax_s    = {INT_W{1'b1}};
  assign smax_s    = {1'b0, {(INT_W-1){1'b1}}};
  assign sat_val_s = INT_W'(sat_bound(sign, uns, INT_W));

  // Rounding increment decision and rounded magnitude.
  always_comb begin
    inexact_s = guard | sticky;
    case (rm)
      RM_RNE:  round_up_s = guard & (sticky | int_mag[0]);
      RM_RTZ:  round_up_s = 1'b0;
      RM_RDN:  round_up_s = sign & inexact_s;
      RM_RUP:  round_up_s = ~sign & inexact_s;
      default: round_up_s = 1'b0;
    endcase
    mag_rnd_s = {1'b0, int_mag} + {{INT_W{1'b0}}, round_up_s};
  end

  // Range checks: signed negative may reach exactly 2^(INT_W-1).
  always_comb begin
    pos_ovf_s = uns ? mag_rnd_s[INT_W] : (mag_rnd_s[INT_W] | mag_rnd_s[INT_W-1]);
    neg_ovf_s = mag_rnd_s[INT_W] | (mag_rnd_s[INT_W-1] & (|mag_rnd_s[INT_W-2:0]));
  end

  // Result selection by class, sign and range.
  always_comb begin
    result = {INT_W{1'b0}};
    flags  = 2'b00;
    case (cls)
      CLS_ZERO: begin
        flags[FLAG_INEXACT] = sticky;
      end
      CLS_NAN: begin
        result              = uns ? umax_s : smax_s;
        flags[FLAG_INVALID] = 1'b1;
      end
      CLS_INF: begin
        result              = sat_val_s;
        flags[FLAG_INVALID] = 1'b1;
      end
      CLS_NORMAL: begin
        if (huge) begin
          result              = sat_val_s;
          flags[FLAG_INVALID] = 1'b1;
        end else if (sign && uns) begin
          // Negative to unsigned is legal only when it rounds to zero.
          if (mag_rnd_s == {(INT_W+1){1'b0}}) begin
            flags[FLAG_INEXACT] = inexact_s;
          end else begin
            flags[FLAG_INVALID] = 1'b1;
          end
        end else if (sign) begin
          if (neg_ovf_s) begin
            result              = sat_val_s;
            flags[FLAG_INVALID] = 1'b1;
          end else begin
            result              = (~mag_rnd_s[INT_W-1:0]) + {{(INT_W-1){1'b0}}, 1'b1};
            flags[FLAG_INEXACT] = inexact_s;
          end
        end else begin
          if (pos_ovf_s) begin
            result              = sat_val_s;
            flags[FLAG_INVALID] = 1'b1;
          end else begin
            result              = mag_rnd_s[INT_W-1:0];
            flags[FLAG_INEXACT] = inexact_s;
          end
        end
      end
      default: begin
        result = {INT_W{1'b0}};
        flags  = 2'b00;
      end
    endcase
  end

endmodule

// File: rtl/ftoi_pipe.sv
// Two-stage float-to-integer converter: S1 unpacks and aligns, S2 rounds,
// saturates and presents the result under valid/ready flow control.
module ftoi_pipe
  import ftoi_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int INT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_data,
  input  logic [1:0]             in_rm,
  input  logic                   in_unsigned,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INT_W-1:0]       out_data,
  output logic [1:0]             out_flags,
  output logic [1:0]             fflags,
  input  logic                   flag_clr
);

  localparam int DW = 1 + EXP_W + MAN_W;
  localparam int AW = MAN_W + INT_W + 2;
  localparam int EW = EXP_W + 2;
  localparam logic signed [EW-1:0] BIAS_E  = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] INT_W_E = EW'(INT_W);
  localparam logic signed [EW-1:0] E_ZERO  = {EW{1'b0}};
  localparam logic signed [EW-1:0] E_NEG1  = {EW{1'b1}};

  logic                    advance_s;
  logic                    retire_s;
  logic                    in_sign_s;
  logic [EXP_W-1:0]        in_exp_s;
  logic [MAN_W-1:0]        in_man_s;
  logic signed [EW-1:0]    e_s;
  logic [AW-1:0]           wide_s;
  logic [AW-1:0]           shifted_s;
  cls_e                    cls_s;
  logic                    huge_s;
  logic [INT_W-1:0]        int_s;
  logic                    guard_s;
  logic                    sticky_s;

  logic                    s1_valid_r;
  logic                    s1_sign_r;
  cls_e                    s1_cls_r;
  logic                    s1_huge_r;
  logic [INT_W-1:0]        s1_int_r;
  logic                    s1_guard_r;
  logic                    s1_sticky_r;
  rm_e                     s1_rm_r;
  logic                    s1_uns_r;

  logic [INT_W-1:0]        rnd_data_s;
  logic [1:0]              rnd_flags_s;
  logic                    out_valid_r;
  logic [INT_W-1:0]        out_data_r;
  logic [1:0]              out_flags_r;
  logic [1:0]              fflags_r;

  assign advance_s = ~out_valid_r | out_ready;
  assign retire_s  = out_valid_r & out_ready;
  assign in_ready  = advance_s & ~rst;

  assign in_sign_s = in_data[DW-1];
  assign in_exp_s  = in_data[MAN_W +: EXP_W];
  assign in_man_s  = in_data[MAN_W-1:0];
  assign e_s       = $signed({2'b00, in_exp_s}) - BIAS_E;
  assign wide_s    = {{(INT_W+1){1'b0}}, 1'b1, in_man_s};
  assign shifted_s = wide_s << $unsigned(e_s);

  // S1 classify and align: binary point sits MAN_W bits above the LSB.
  always_comb begin
    cls_s    = CLS_ZERO;
    huge_s   = 1'b0;
    int_s    = {INT_W{1'b0}};
    guard_s  = 1'b0;
    sticky_s = 1'b0;
    if (in_exp_s == {EXP_W{1'b0}}) begin
      sticky_s = |in_man_s;
    end else if (in_exp_s == {EXP_W{1'b1}}) begin
      cls_s = (in_man_s == {MAN_W{1'b0}}) ? CLS_INF : CLS_NAN;
    end else begin
      cls_s = CLS_NORMAL;
      if ((e_s >= INT_W_E) || (|shifted_s[AW-1 -: 2])) begin
        huge_s = 1'b1;
      end else if (e_s >= E_ZERO) begin
        int_s    = shifted_s[MAN_W +: INT_W];
        guard_s  = shifted_s[MAN_W-1];
        sticky_s = |shifted_s[MAN_W-2:0];
      end else if (e_s == E_NEG1) begin
        guard_s  = 1'b1;
        sticky_s = |in_man_s;
      end else begin
        sticky_s = 1'b1;
      end
    end
  end

  // S1 operand payload; captured whenever the pipeline advances.
  always_ff @(posedge clk) begin
    if (advance_s) begin
      s1_sign_r   <= in_sign_s;
      s1_cls_r    <= cls_s;
      s1_huge_r   <= huge_s;
      s1_int_r    <= int_s;
      s1_guard_r  <= guard_s;
      s1_sticky_r <= sticky_s;
      s1_rm_r     <= rm_e'(in_rm);
      s1_uns_r    <= in_unsigned;
    end
  end

  ftoi_round #(
    .INT_W (INT_W)
  ) u_round (
    .sign    (s1_sign_r),
    .cls     (s1_cls_r),
    .huge    (s1_huge_r),
    .int_mag (s1_int_r),
    .guard   (s1_guard_r),
    .sticky  (s1_sticky_r),
    .rm      (s1_rm_r),
    .uns     (s1_uns_r),
    .result  (rnd_data_s),
    .flags   (rnd_flags_s)
  );

  // Valid bits and S2 output register; everything holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {INT_W{1'b0}};
      out_flags_r <= 2'b00;
    end else if (advance_s) begin
      s1_valid_r  <= in_valid;
      out_valid_r <= s1_valid_r;
      out_data_r  <= rnd_data_s;
      out_flags_r <= rnd_flags_s;
    end
  end

  // Sticky flags; a clear coinciding with a retire keeps only the retiring flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      fflags_r <= 2'b00;
    end else if (flag_clr) begin
      fflags_r <= retire_s ? out_flags_r : 2'b00;
    end else if (retire_s) begin
      fflags_r <= fflags_r | out_flags_r;
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_flags = out_flags_r;
  assign fflags    = fflags_r;

endmodule

// File: tb/tb_ftoi_pipe.sv
// Scoreboard bench for ftoi_pipe: real-arithmetic reference model, random
// and directed operands, stall, flag-clear and mid-stream reset scenarios.
module tb_ftoi_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic [1:0]  in_rm = 2'b00;
  logic        in_unsigned = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [1:0]  out_flags;
  logic [1:0]  fflags;
  logic        flag_clr = 1'b0;

  int          total = 0;
  int          bad = 0;
  logic [33:0] sb[$];
  logic [33:0] cur_exp = 34'h0;
  logic        cur_use = 1'b0;
  logic        rand_ready = 1'b0;
  logic [1:0]  exp_ff = 2'b00;
  logic        prev_stall = 1'b0;
  logic [31:0] held_data = 32'h0;
  logic [1:0]  held_flags = 2'b00;
  logic [33:0] exp_item;

  ftoi_pipe #(.EXP_W(8), .MAN_W(23), .INT_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_rm(in_rm), .in_unsigned(in_unsigned),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_flags(out_flags), .fflags(fflags), .flag_clr(flag_clr)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endfunction

  // Reference: exact real value, rounded by mode, then range-checked. Returns {invalid, inexact, data}.
  function automatic logic [33:0] ref_model(logic [31:0] f, logic [1:0] rm, logic uns);
    int e;
    logic [22:0] m;
    real v, r, fl, lo, hi;
    logic inex;
    longint li;
    e = int'(f[30:23]);
    m = f[22:0];
    if (e == 0) return {1'b0, (m != 23'd0), 32'h0};
    if (e == 255) begin
      if (m != 23'd0) return {2'b10, uns ? 32'hFFFFFFFF : 32'h7FFFFFFF};
      return {2'b10, f[31] ? (uns ? 32'h0 : 32'h80000000) : (uns ? 32'hFFFFFFFF : 32'h7FFFFFFF)};
    end
    v = real'(8388608 + int'(m)) * $pow(2.0, real'(e - 150));
    if (f[31]) v = -v;
    fl = $floor(v);
    case (rm)
      2'd0: begin
        if (v - fl > 0.5) r = fl + 1.0;
        else if (v - fl < 0.5) r = fl;
        else r = ($floor(fl / 2.0) * 2.0 == fl) ? fl : fl + 1.0;
      end
      2'd1: r = (v >= 0.0) ? fl : $ceil(v);
      2'd2: r = fl;
      default: r = $ceil(v);
    endcase
    inex = (r != v);
    lo = uns ? 0.0 : -2147483648.0;
    hi = uns ? 4294967295.0 : 2147483647.0;
    if (uns && v < 0.0) return (r == 0.0) ? {1'b0, inex, 32'h0} : {2'b10, 32'h0};
    if (r > hi) return {2'b10, uns ? 32'hFFFFFFFF : 32'h7FFFFFFF};
    if (r < lo) return {2'b10, 32'h80000000};
    li = longint'(r);
    return {1'b0, inex, li[31:0]};
  endfunction

  function automatic logic [31:0] rand_float();
    logic [7:0]  e;
    logic [22:0] m;
    logic        s;
    s = 1'($urandom_range(0, 1));
    m = 23'($urandom);
    case ($urandom_range(0, 9))
      0: e = 8'd0;
      1: begin e = 8'd255; if ($urandom_range(0, 1) == 1) m = 23'd0; end
      2: e = 8'($urandom_range(150, 160));
      3: begin e = 8'($urandom_range(126, 140)); m = m & 23'h7FF000; end
      default: e = 8'($urandom_range(100, 158));
    endcase
    return {s, e, m};
  endfunction

  // Accept side of the scoreboard.
  always @(negedge clk) begin
    if (!rst && in_valid && in_ready)
      sb.push_back(cur_use ? cur_exp : ref_model(in_data, in_rm, in_unsigned));
  end

  // Retire side: compare results, check holding while stalled, track fflags.
  always @(negedge clk) begin
    chk("fflags", {62'd0, fflags}, {62'd0, exp_ff});
    if (prev_stall) begin
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_data", {32'd0, out_data}, {32'd0, held_data});
      chk("hold_flags", {62'd0, out_flags}, {62'd0, held_flags});
    end
    if (rst) begin
      sb.delete();
      exp_ff = 2'b00;
      prev_stall = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %h want no result", out_data);
          exp_item = 34'h0;
        end else begin
          exp_item = sb.pop_front();
          chk("out_data", {32'd0, out_data}, {32'd0, exp_item[31:0]});
          chk("out_flags", {62'd0, out_flags}, {62'd0, exp_item[33:32]});
        end
        exp_ff = flag_clr ? exp_item[33:32] : (exp_ff | exp_item[33:32]);
      end else if (flag_clr) begin
        exp_ff = 2'b00;
      end
      prev_stall = out_valid && !out_ready;
      held_data = out_data;
      held_flags = out_flags;
    end
  end

  // Offer one operand; called and returns at posedge+1.
  task automatic send(input logic [31:0] d, input logic [1:0] rm, input logic u,
                      input logic use_e, input logic [33:0] e);
    logic ok;
    ok = 1'b0;
    cur_exp = e; cur_use = use_e;
    in_data = d; in_rm = rm; in_unsigned = u; in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
      @(posedge clk); #1;
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drain();
    rand_ready = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    chk("drain", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  logic [31:0] dir_d [11] = '{32'h3FC00000, 32'h40200000, 32'hBFC00000, 32'hBFC00000,
                              32'hBFC00000, 32'h4F000000, 32'hCF000000, 32'h4F000000,
                              32'h7FC00000, 32'hFF800000, 32'hBE99999A};
  logic [1:0]  dir_rm [11] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
  logic        dir_u [11]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic [33:0] dir_e [11]  = '{{2'b01, 32'h2}, {2'b01, 32'h2}, {2'b01, 32'hFFFFFFFF},
                              {2'b01, 32'hFFFFFFFE}, {2'b01, 32'hFFFFFFFF}, {2'b10, 32'h7FFFFFFF},
                              {2'b00, 32'h80000000}, {2'b00, 32'h80000000}, {2'b10, 32'h7FFFFFFF},
                              {2'b10, 32'h0}, {2'b01, 32'h0}};

  initial begin
    int idx, cyc;
    logic acc, saw_low;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", {32'd0, out_data}, 64'd0);
    chk("rst_out_flags", {62'd0, out_flags}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Latency from an idle pipeline.
    send(32'h40490FDB, 2'd0, 1'b0, 1'b1, {2'b01, 32'h3});
    @(negedge clk);
    chk("latency_c1", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk("latency_c2", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) send(dir_d[i], dir_rm[i], dir_u[i], 1'b1, dir_e[i]);
    drain();

    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++)
      send(rand_float(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 34'h0);
    drain();

    // Stall: consumer blocks for 5 cycles while 4 operands are offered.
    out_ready = 1'b0; idx = 0; cyc = 0; saw_low = 1'b0;
    cur_use = 1'b0;
    in_data = rand_float(); in_rm = 2'($urandom_range(0, 3)); in_unsigned = 1'b0; in_valid = 1'b1;
    while (idx < 4 && cyc < 100) begin
      @(negedge clk);
      acc = in_ready;
      if (!in_ready) saw_low = 1'b1;
      @(posedge clk); #1;
      cyc++;
      if (cyc == 5) out_ready = 1'b1;
      if (acc) begin
        idx++;
        if (idx < 4) begin
          in_data = rand_float(); in_rm = 2'($urandom_range(0, 3));
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    chk("stall_in_ready_low", {63'd0, saw_low}, 64'd1);
    chk("stall_accepted", 64'(idx), 64'd4);
    drain();

    // Flag clear coinciding with an inexact retire.
    flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    send(32'h7FC00000, 2'd0, 1'b0, 1'b1, {2'b10, 32'h7FFFFFFF});
    drain();
    chk("fflags_nan", {62'd0, fflags}, 64'd2);
    out_ready = 1'b0;
    send(32'h40490FDB, 2'd0, 1'b0, 1'b1, {2'b01, 32'h3});
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    @(posedge clk); #1;
    out_ready = 1'b1; flag_clr = 1'b1;
    @(posedge clk); #1;
    flag_clr = 1'b0;
    @(negedge clk);
    chk("clr_on_retire", {62'd0, fflags}, 64'd1);
    @(posedge clk); #1;

    // Reset in the middle of a stream.
    rand_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      send(rand_float(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0, 34'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_fflags", {62'd0, fflags}, 64'd0);
    rst = 1'b0;
    rand_ready = 1'b0;
    out_ready = 1'b1;
    send(32'h3FC00000, 2'd0, 1'b0, 1'b1, {2'b01, 32'h2});
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ftoi_pipe.md
FTOI_PIPE -- requirements
Module: ftoi_pipe

Interface
REQ-001 Parameter EXP_W, 8, exponent width of the float input.
REQ-002 Parameter MAN_W, 23, stored mantissa width (hidden bit excluded).
REQ-003 Parameter INT_W, 32, integer result width; legal range 8..64.
REQ-004 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port in_valid  input  1  input operand present.
REQ-007 Port in_ready  output  1  block accepts operand this cycle.
REQ-008 Port in_data  input  1+EXP_W+MAN_W  float operand {sign, exp, man}.
REQ-009 Port in_rm  input  2  rounding mode: 00 RNE, 01 RTZ, 10 RDN (toward -inf), 11 RUP (toward +inf).
REQ-010 Port in_unsigned  input  1  1 = unsigned result range, 0 = two's-complement.
REQ-011 Port out_valid  output  1  result present.
REQ-012 Port out_ready  input  1  consumer takes result this cycle.
REQ-013 Port out_data  output  INT_W  integer result.
REQ-014 Port out_flags  output  2  per-result {invalid, inexact}.
REQ-015 Port fflags  output  2  sticky accumulated {invalid, inexact}.
REQ-016 Port flag_clr  input  1  clears fflags.

Function
REQ-017 Transfer occurs on in_valid&in_ready (accept) and out_valid&out_ready (retire); in_rm and in_unsigned are captured with in_data.
REQ-018 Two registered stages: S1 unpack/classify/align (integer part, guard, sticky); S2 round/negate/saturate/flags, S2 register drives outputs.
REQ-019 Latency exactly 2 cycles accept-to-out_valid when unstalled; throughput one per cycle.
REQ-020 Pipeline advances when !out_valid | out_ready; in_ready equals that term and is 0 while rst is high.
REQ-021 While out_valid&!out_ready, out_data, out_flags and out_valid hold stable; no operand is dropped, duplicated or reordered.
REQ-022 Exponent 0 (zero/denormal): result 0; inexact = (man != 0); rounding mode ignored.
REQ-023 Finite normal: value = 1.man * 2^(exp-bias), bias = 2^(EXP_W-1)-1; magnitudes < 1 produce guard/sticky only; alignment datapath is MAN_W+INT_W+2 bits wide.
REQ-024 Rounding on magnitude with sign: RNE ties to even; RTZ truncates; RDN increments when negative and inexact; RUP increments when positive and inexact.
REQ-025 Signed range [-2^(INT_W-1), 2^(INT_W-1)-1]; -2^(INT_W-1) exact is valid with no flags.
REQ-026 Out of range after rounding: saturate to nearest bound (signed max/min, unsigned max or 0), invalid=1, inexact=0.
REQ-027 Unsigned mode, negative input: rounded magnitude 0 -> result 0, invalid=0, inexact per REQ-024; nonzero -> result 0, invalid=1.
REQ-028 NaN: result signed max or unsigned max, invalid=1; +inf saturates to max, -inf to signed min or 0, invalid=1.
REQ-029 fflags ORs in out_flags on each retire; flag_clr zeroes fflags; clear and retire in same cycle leave only the retiring flags set.

Reset
REQ-030 On rst: S1/S2 valid bits, out_data, out_flags and fflags clear to 0 at the next edge.
REQ-031 Reset mid-operation discards all in-flight operands; out_valid is 0 the cycle after rst is sampled.

Structure
REQ-032 Shared package ftoi_pkg holds the rounding-mode enum, flag bit indices {INVALID=1, INEXACT=0} and the operand-class typedef (zero, normal, inf, nan).
REQ-033 S2 rounding/saturation is sub-module ftoi_round, purely combinational, parametrised by INT_W.

Verification
REQ-034 0x40490FDB, RNE, signed -> 0x00000003, flags 01, out_valid exactly 2 cycles after accept.
REQ-035 RNE 0x3FC00000 -> 2, 0x40200000 -> 2; 0xBFC00000 with RTZ -> 0xFFFFFFFF, RDN -> 0xFFFFFFFE, RUP -> 0xFFFFFFFF.
REQ-036 Signed 0x4F000000 -> 0x7FFFFFFF flags 10; 0xCF000000 -> 0x80000000 flags 00; unsigned 0x4F000000 -> 0x80000000 flags 00.
REQ-037 0x7FC00000 -> 0x7FFFFFFF flags 10; 0xFF800000 unsigned -> 0 flags 10; 0xBE99999A unsigned RTZ -> 0 flags 01.
REQ-038 out_ready low 5 cycles while 4 operands offered -> in_ready drops after pipeline fills, out_data stable, all 4 results retire in order.
REQ-039 flag_clr asserted on the cycle an inexact result retires -> fflags = 01; rst pulse mid-stream -> out_valid 0 next cycle, fflags 00.
